ula_input_ctrl: RTL and testbench
=================================

Name: ula_input_ctrl

Overview:
- Registered input stage directly upstream of the ALU top level.
- Synchronises and debounces the two active-low push-buttons and the slide switches.
- KEY0 steps through the 3-bit operation code; KEY1 commits operands, carry-in and opcode into output registers.
- Drives the ALU's a/b/cin/seletor inputs with glitch-free, stable values, plus a one-cycle commit strobe.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples (clk cycles) before a key level is accepted; 10 ms at 50 MHz.
- NUM_OPS, 7, number of valid opcodes; pending opcode wraps from NUM_OPS-1 to 0; code 7 is never produced.
- REPEAT_CYCLES, 25000000, auto-repeat period for held KEY0 (optional feature only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw  input  10  raw slide switches; [3:0]=A, [7:4]=B, [8]=carry-in, [9] ignored
- key_n  input  2  raw push-buttons, active-low (0 = pressed)
- a  output  4  committed operand A
- b  output  4  committed operand B
- cin  output  1  committed carry-in
- seletor  output  3  committed opcode to ALU mux
- op_valid  output  1  one-cycle pulse, high the cycle after a commit load
- dirty  output  1  high while synced switches[8:0] or pending opcode differ from committed values

Behaviour:
- Reset is asynchronous and active-low: rst_n low clears a, b, cin, seletor, op_valid, pending opcode and FSM state to 0 or IDLE immediately. Synchroniser flops reset to 1 for key_n and to 0 for sw. Debounced key levels reset to released (1).
- Synchronisation: 2-flop synchroniser on every key_n and sw bit. All logic uses the synced values.
- Debounce, per key:
  - Counter resets whenever the synced level equals the accepted level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the accepted level toggles and the counter clears.
  - Press event = accepted level transitions 1->0, one cycle wide.
  - Latency from a clean raw edge to the press event is 2 + DEBOUNCE_CYCLES cycles.
- Pending opcode (3-bit):
  - Increments on each KEY0 press event in any FSM state.
  - Value NUM_OPS-1 wraps to 0.
- FSM states:
  - IDLE: on KEY1 press -> COMMIT.
  - COMMIT (1 cycle): load a=sw[3:0], b=sw[7:4], cin=sw[8], seletor=pending opcode (value before any same-cycle increment); go to WAIT_REL.
  - WAIT_REL: stay until KEY1 accepted level returns to 1, then -> IDLE. Further KEY1 presses cannot occur here.
- op_valid is registered high in the cycle after COMMIT, for exactly one cycle.
- Simultaneous KEY0 and KEY1 press events in the same cycle: the commit takes the old opcode; the pending opcode still increments.
- Outputs change only in COMMIT. Switch motion outside COMMIT never disturbs a/b/cin/seletor.
- dirty is combinational from registers: (sync sw[8:0] != {cin,b,a}) or (pending != seletor).
- Reset asserted mid-debounce or in WAIT_REL: everything returns to reset values. A key still held after reset release is debounced and generates a press event.

Optional Feature:
- Macro: ULA_AUTO_REPEAT_EN.
- Defined:
  - While KEY0's accepted level stays 0, a repeat counter generates an extra increment every REPEAT_CYCLES cycles after the press event.
  - The counter clears on release.
- Undefined: exactly one increment per press; no repeat counter is synthesised.

Decomposition:
- Shared package ula_pkg:
  - opcode width 3.
  - Constants OP_SOMA=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_MULT=4, OP_XOR=5, OP_DIV=6, OP_NONE=7.
  - FSM state encoding IDLE/COMMIT/WAIT_REL.
- Sub-module debounce_key (synchroniser + counter + press-event output):
  - Instantiated once per key.
  - Parameterised by DEBOUNCE_CYCLES.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16):
- Reset: rst_n=0 mid-run -> a=0, b=0, cin=0, seletor=0, op_valid=0, dirty=0 asynchronously, without waiting for a clk edge.
- Bounce rejection: key_n[0] toggles 1/0 every 2 cycles for 20 cycles, then held 0 -> exactly one increment, pending 0->1; no increment during bouncing.
- Wrap: 7 clean KEY0 presses from reset -> pending sequence 1,2,3,4,5,6,0; the value 7 never appears.
- Commit: sw=10'b0_1_0101_0011, pending=4, clean KEY1 press -> a=3, b=5, cin=1, seletor=4; op_valid high exactly one cycle, 2+4+2 cycles after the raw edge; dirty falls to 0.
- Simultaneous: pending=2, KEY0 and KEY1 events land in the same cycle -> seletor=2, pending=3, dirty=1.
- Hold/stability: KEY1 held 100 cycles while sw changes -> single op_valid, outputs unchanged, dirty=1. With ULA_AUTO_REPEAT_EN, KEY0 held 50 cycles after its press -> 1+3 increments.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU input controller: opcode encoding, FSM states
// and the pending-opcode step helper.
package ula_pkg;

  localparam int OP_WIDTH = 3;

  typedef logic [OP_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_SOMA = 3'd0;
  localparam opcode_t OP_SUB  = 3'd1;
  localparam opcode_t OP_AND  = 3'd2;
  localparam opcode_t OP_OR   = 3'd3;
  localparam opcode_t OP_MULT = 3'd4;
  localparam opcode_t OP_XOR  = 3'd5;
  localparam opcode_t OP_DIV  = 3'd6;
  localparam opcode_t OP_NONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // The last valid opcode wraps to zero, so OP_NONE is never reached.
  function automatic opcode_t nextOp(input opcode_t op, input int numOps);
    if (int'(op) >= numOps - 1)
      return OP_SOMA;
    return opcode_t'(op + 3'd1);
  endfunction

endpackage

// File: rtl/ula_input_ctrl_debounce.sv
// debounce_key: 2-flop synchroniser, stability counter and one-cycle press
// event for a single active-low push-button.
module debounce_key #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_keyN,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_levelDly;
  logic [CW-1:0] r_count;

  // The accepted level only flips after the synced level has disagreed with
  // it for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_level    <= 1'b1;
      r_levelDly <= 1'b1;
      r_count    <= '0;
    end else begin
      r_sync1    <= i_keyN;
      r_sync2    <= r_sync1;
      r_levelDly <= r_level;
      if (r_sync2 == r_level) begin
        r_count <= '0;
      end else if (r_count == LAST) begin
        r_level <= ~r_level;
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_levelDly & ~r_level;

endmodule

// File: rtl/ula_input_ctrl.sv
// ula_input_ctrl: registered switch/key input stage feeding the ALU top level.
// Define ULA_AUTO_REPEAT_EN to auto-repeat opcode stepping while KEY0 is held.
module ula_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_OPS         = 7,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  input  logic [1:0] key_n,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic [2:0] seletor,
  output logic       op_valid,
  output logic       dirty
);

  import ula_pkg::*;

  logic [9:0] r_swSync1;
  logic [9:0] r_swSync2;
  logic       w_key0Level;
  logic       w_key0Press;
  logic       w_key1Level;
  logic       w_key1Press;
  logic       w_repeatTick;
  logic       w_opStep;
  logic       w_unusedSw9;
  opcode_t    r_pending;
  opcode_t    r_snapOp;
  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_cin;
  opcode_t    r_seletor;
  logic       r_opValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_swSync1 <= '0;
      r_swSync2 <= '0;
    end else begin
      r_swSync1 <= sw;
      r_swSync2 <= r_swSync1;
    end
  end

  assign w_unusedSw9 = r_swSync2[9];

  debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_keyN  (key_n[0]),
    .o_level (w_key0Level),
    .o_press (w_key0Press)
  );

  debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_keyN  (key_n[1]),
    .o_level (w_key1Level),
    .o_press (w_key1Press)
  );

`ifdef ULA_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_repeatCount;

  // Free-runs from the press event while KEY0 stays accepted as pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_repeatCount <= '0;
    else if (w_key0Level || w_repeatTick)
      r_repeatCount <= '0;
    else
      r_repeatCount <= r_repeatCount + RW'(1);
  end

  assign w_repeatTick = !w_key0Level && (r_repeatCount == REP_LAST);
`else
  logic w_unusedRepeat;

  assign w_repeatTick   = 1'b0;
  assign w_unusedRepeat = w_key0Level & (REPEAT_CYCLES > 0);
`endif

  assign w_opStep = w_key0Press | w_repeatTick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pending <= OP_SOMA;
    else if (w_opStep)
      r_pending <= nextOp(r_pending, NUM_OPS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_key1Press) w_nextState = COMMIT;
      COMMIT:   w_nextState = WAIT_REL;
      WAIT_REL: if (w_key1Level) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // The opcode is captured with the KEY1 event so a KEY0 event in the same
  // cycle cannot leak its increment into the commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_snapOp <= OP_SOMA;
    else if (r_state == IDLE && w_key1Press)
      r_snapOp <= r_pending;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_seletor <= OP_SOMA;
      r_opValid <= 1'b0;
    end else begin
      r_opValid <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_a       <= r_swSync2[3:0];
        r_b       <= r_swSync2[7:4];
        r_cin     <= r_swSync2[8];
        r_seletor <= r_snapOp;
      end
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign cin      = r_cin;
  assign seletor  = r_seletor;
  assign op_valid = r_opValid;
  assign dirty    = (r_swSync2[8:0] != {r_cin, r_b, r_a}) || (r_pending != r_seletor);

endmodule

// File: tb/tb_ula_input_ctrl.sv
// Self-checking bench for ula_input_ctrl; the model tracks the pending opcode as
// a press count modulo NUM_OPS and the committed values as plain switch fields.
module tb_ula_input_ctrl;

  localparam int DEB  = 4;
  localparam int REP  = 16;
  localparam int NOPS = 7;
  localparam int SETTLE = DEB + 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] sw = '0;
  logic [1:0] key_n = 2'b11;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [2:0] seletor;
  logic       op_valid;
  logic       dirty;

  int vectors = 0;
  int miscompares = 0;
  int modelPending = 0;

  ula_input_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .NUM_OPS         (NOPS),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .key_n    (key_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .seletor  (seletor),
    .op_valid (op_valid),
    .dirty    (dirty)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hardReset;
    @(negedge clk);
    rst_n = 1'b0;
    key_n = 2'b11;
    sw = '0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    modelPending = 0;
  endtask

  task automatic pressKey0;
    key_n[0] = 1'b0;
    cycles(SETTLE);
    key_n[0] = 1'b1;
    cycles(SETTLE);
    modelPending = (modelPending + 1) % NOPS;
  endtask

  // Clean KEY1 press/release with the given switches; checks a single strobe
  // and the committed fields against the switch word and the model opcode.
  task automatic doCommit(input logic [8:0] v, input string tag);
    int pulses = 0;
    logic [11:0] expOut;
    sw = {1'($urandom_range(0, 1)), v};
    cycles(3);
    key_n[1] = 1'b0;
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      if (op_valid) pulses++;
    end
    key_n[1] = 1'b1;
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      if (op_valid) pulses++;
    end
    expOut = {v[8], v[7:4], v[3:0], 3'(modelPending)};
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL %s op_valid pulses: got %0d expected 1", tag, pulses);
    end
    vectors++;
    if ({cin, b, a, seletor} !== expOut) begin
      miscompares++;
      $display("[TB] FAIL %s outputs {cin,b,a,sel}: got %h expected %h", tag, {cin, b, a, seletor}, expOut);
    end
    vectors++;
    if (seletor === 3'd7) begin
      miscompares++;
      $display("[TB] FAIL %s seletor: got 7 expected a valid opcode", tag);
    end
    vectors++;
    if (dirty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s dirty after commit: got %b expected 0", tag, dirty);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({a, b, cin, seletor, op_valid, dirty} !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_initial: got %h expected 0", {a, b, cin, seletor, op_valid, dirty});
    end
    hardReset();
  endtask

  task automatic test_async_reset;
    hardReset();
    pressKey0();
    doCommit(9'h1A5, "pre_async");
    key_n[0] = 1'b0;
    cycles(3);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({a, b, cin, seletor, op_valid, dirty} !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h expected 0", {a, b, cin, seletor, op_valid, dirty});
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelPending = 0;
    cycles(SETTLE);
    key_n[0] = 1'b1;
    cycles(SETTLE);
    modelPending = 1;
    doCommit(9'($urandom_range(0, 511)), "held_after_reset");
  endtask

  task automatic test_bounce;
    int dirtySeen = 0;
    hardReset();
    for (int i = 0; i < 20; i++) begin
      key_n[0] = ((i / 2) % 2) == 1;
      @(negedge clk);
      if (dirty) dirtySeen++;
    end
    vectors++;
    if (dirtySeen !== 0) begin
      miscompares++;
      $display("[TB] FAIL bounce_no_step: got %0d dirty cycles expected 0", dirtySeen);
    end
    key_n[0] = 1'b0;
    cycles(SETTLE);
    vectors++;
    if (dirty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bounce_step: got dirty %b expected 1", dirty);
    end
    key_n[0] = 1'b1;
    cycles(SETTLE);
    modelPending = 1;
    doCommit(9'($urandom_range(0, 511)), "bounce_commit");
  endtask

  task automatic test_wrap;
    hardReset();
    for (int k = 0; k < 7; k++) begin
      pressKey0();
      doCommit(9'($urandom_range(0, 511)), $sformatf("wrap_%0d", k));
    end
  endtask

  task automatic test_commit;
    hardReset();
    repeat (4) pressKey0();
    sw = 10'b0_1_0101_0011;
    cycles(4);
    vectors++;
    if (dirty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL commit_pre_dirty: got %b expected 1", dirty);
    end
    key_n[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (op_valid !== (k == 2 + DEB + 2)) begin
        miscompares++;
        $display("[TB] FAIL commit_strobe_cycle%0d: got %b expected %b", k, op_valid, (k == 2 + DEB + 2));
      end
    end
    key_n[1] = 1'b1;
    cycles(SETTLE);
    vectors++;
    if ({a, b, cin, seletor} !== {4'd3, 4'd5, 1'b1, 3'd4}) begin
      miscompares++;
      $display("[TB] FAIL commit_values {a,b,cin,sel}: got %h expected %h", {a, b, cin, seletor}, {4'd3, 4'd5, 1'b1, 3'd4});
    end
    vectors++;
    if (dirty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL commit_dirty: got %b expected 0", dirty);
    end
  endtask

  task automatic test_simultaneous;
    logic [8:0] v;
    hardReset();
    repeat (2) pressKey0();
    v = 9'($urandom_range(0, 511));
    sw = {1'b0, v};
    cycles(3);
    key_n = 2'b00;
    cycles(SETTLE);
    key_n = 2'b11;
    cycles(SETTLE);
    vectors++;
    if ({cin, b, a, seletor} !== {v, 3'd2}) begin
      miscompares++;
      $display("[TB] FAIL simultaneous_commit: got %h expected %h", {cin, b, a, seletor}, {v, 3'd2});
    end
    vectors++;
    if (dirty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL simultaneous_dirty: got %b expected 1", dirty);
    end
    modelPending = 3;
    doCommit(v, "simultaneous_followup");
  endtask

  task automatic test_hold;
    logic [8:0] v;
    int pulses = 0;
    int unstable = 0;
    bit seen = 0;
    hardReset();
    pressKey0();
    v = 9'($urandom_range(0, 511));
    sw = {1'b0, v};
    cycles(3);
    key_n[1] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (op_valid) begin
        pulses++;
        seen = 1;
      end
      if (seen) begin
        if ({cin, b, a, seletor} !== {v, 3'(modelPending)}) unstable++;
        sw = 10'($urandom_range(0, 1023));
      end
    end
    sw = {1'b0, v[8:1], ~v[0]};
    cycles(3);
    vectors++;
    if (dirty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_dirty: got %b expected 1", dirty);
    end
    key_n[1] = 1'b1;
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      if (op_valid) pulses++;
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL hold_pulses: got %0d expected 1", pulses);
    end
    vectors++;
    if (unstable !== 0 || {cin, b, a, seletor} !== {v, 3'(modelPending)}) begin
      miscompares++;
      $display("[TB] FAIL hold_stable: got %h (%0d unstable cycles) expected %h", {cin, b, a, seletor}, unstable, {v, 3'(modelPending)});
    end
  endtask

  task automatic test_auto_repeat;
    hardReset();
    key_n[0] = 1'b0;
    cycles(2 + DEB);
    cycles(50);
    key_n[0] = 1'b1;
    cycles(SETTLE);
`ifdef ULA_AUTO_REPEAT_EN
    modelPending = (1 + 50 / REP) % NOPS;
`else
    modelPending = 1;
`endif
    doCommit(9'($urandom_range(0, 511)), "auto_repeat");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_commit();
    test_simultaneous();
    test_hold();
    test_auto_repeat();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
